// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache
// controllers; one requester owns the port from grant until its pmem_resp.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
  logic   req_d;

  assign req_d = d_pmem_read | d_pmem_write;

  // Read data fans out to both caches; each qualifies it with its own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    case (state_q)
      StIdle: begin
        // On a tie, grant whichever side did not win last time.
        if (i_pmem_read && req_d) begin
          if (last_grant_q) begin
            state_d      = StGrantI;
            last_grant_d = 1'b0;
          end else begin
            state_d      = StGrantD;
            last_grant_d = 1'b1;
          end
        end else if (i_pmem_read) begin
          state_d      = StGrantI;
          last_grant_d = 1'b0;
        end else if (req_d) begin
          state_d      = StGrantD;
          last_grant_d = 1'b1;
        end
      end

      StGrantI: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = StIdle;
      end

      StGrantD: begin
        // Write wins over a simultaneous read.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache and data-cache controllers of the split-cache LC-3 datapath.
- Each cache controller issues line-sized pmem_read/pmem_write requests that it holds until it sees a one-cycle pmem_resp.
- This block grants one requester at a time, muxes address, write data and command onto the memory port, and routes the response back only to the granted requester.
- Round-robin arbitration on simultaneous requests.

Parameters:
- ADDR_WIDTH, 16, byte address width of pmem requests.
- LINE_WIDTH, 128, cache line width in bits (rdata/wdata).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line fill request, held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  fill data to I-cache
- i_pmem_resp  out  1  one-cycle completion to I-cache
- d_pmem_read  in  1  D-cache line fill request
- d_pmem_write  in  1  D-cache writeback request
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
- d_pmem_rdata  out  LINE_WIDTH  fill data to D-cache
- d_pmem_resp  out  1  one-cycle completion to D-cache
- pmem_read  out  1  read command to physical memory
- pmem_write  out  1  write command to physical memory
- pmem_address  out  ADDR_WIDTH  address to physical memory
- pmem_wdata  out  LINE_WIDTH  write data to physical memory
- pmem_rdata  in  LINE_WIDTH  read data from physical memory
- pmem_resp  in  1  completion from physical memory

Behaviour:
- States:
  - IDLE: no grant.
  - GRANT_I: I-cache owns the port.
  - GRANT_D: D-cache owns the port.
- Additional register: last_grant (0 = I, 1 = D).
- Reset (synchronous):
  - state <= IDLE, last_grant <= 1, so the I-cache wins the first tie.
  - A reset mid-transfer abandons the grant immediately. Physical memory is reset in the same cycle.
- In IDLE, all outputs are 0: pmem_read, pmem_write, i_pmem_resp, d_pmem_resp. pmem_address and pmem_wdata are 0.
- IDLE transitions, where req_d = d_pmem_read | d_pmem_write:
  - Only i_pmem_read -> GRANT_I.
  - Only req_d -> GRANT_D.
  - Both -> grant the requester not equal to last_grant.
  - Neither -> stay in IDLE.
- On every transition into GRANT_x, last_grant <= x.
- GRANT_I:
  - pmem_read = i_pmem_read, pmem_write = 0, pmem_address = i_pmem_address, pmem_wdata = 0.
  - i_pmem_resp = pmem_resp.
  - On pmem_resp -> IDLE.
- GRANT_D:
  - pmem_write = d_pmem_write.
  - pmem_read = d_pmem_read & ~d_pmem_write: write wins if both are asserted, which is illegal but defined.
  - pmem_address = d_pmem_address, pmem_wdata = d_pmem_wdata.
  - d_pmem_resp = pmem_resp.
  - On pmem_resp -> IDLE.
- The non-granted requester's resp is always 0. A pmem_resp arriving in IDLE is ignored and forwarded to no one.
- i_pmem_rdata and d_pmem_rdata are both driven combinationally by pmem_rdata. Requesters qualify the data with their own resp.
- Latency:
  - Grant takes effect the cycle after the request is first seen in IDLE (1-cycle arbitration).
  - After each pmem_resp there is exactly one IDLE cycle before the next grant. This lets the requester's controller drop or change its command.
  - Overhead per transfer is 1 cycle plus memory latency.
- Grant is held until pmem_resp regardless of requester behaviour. If the granted requester deasserts its command early, the memory command follows it; requesters must hold commands stable until resp.
- A D-cache writeback followed by a fill is two separate transactions. If the I-cache is waiting, it is served between them, per round robin.
- No starvation: under continuous contention, grants strictly alternate I, D, I, D.
- All outputs are combinational from state and inputs. Only state and last_grant are registered.

Test Plan:
- Reset, then only i_pmem_read=1 with address 0x3000, memory responds after 3 cycles with rdata 0xA5..A5 -> GRANT_I next cycle; pmem_read=1, pmem_address=0x3000; i_pmem_resp=1 for exactly 1 cycle with i_pmem_rdata=0xA5..A5; d_pmem_resp stays 0; IDLE for 1 cycle after.
- d_pmem_write=1 with address 0x4010 and wdata 0x1234..: pmem_write=1, pmem_read=0, pmem_wdata matches. Then d_pmem_read=1 on 0x4020 the cycle after resp -> new grant after a 1-cycle IDLE gap.
- i_pmem_read and d_pmem_read asserted together from reset, both held -> grant order I, D, I, D over 4 transfers; each resp reaches only its owner.
- D granted with i_pmem_read arriving mid-transfer -> pmem_address stays the D-cache address until pmem_resp; I granted 2 cycles after d_pmem_resp.
- reset asserted during GRANT_D while pmem_resp is pending -> next cycle IDLE, all commands 0, last_grant=1. A subsequent simultaneous I and D request grants I.
- Spurious pmem_resp=1 in IDLE -> both i_pmem_resp and d_pmem_resp remain 0 and state stays IDLE.
